// File: rtl/grey_incr_sched_pkg.sv
// Shared widths and FSM state encoding for the grey-counter increment scheduler.
package grey_incr_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int BW_DEF   = 4;
  localparam int DW_DEF   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/grey_incr_sched_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int LW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [LW-1:0]   win_idx
);

  int          idx;
  logic [LW-1:0] idx_l;
  logic        found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_l   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx   = (int'(last) + 1 + i) % NREQ;
      idx_l = LW'(idx);
      if (!found && req[idx_l]) begin
        found        = 1'b1;
        win_idx      = idx_l;
        win[idx_l]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grey_incr_sched.sv
// Round-robin scheduler issuing gap-spaced incr bursts to a shared grey counter.
module grey_incr_sched
  import grey_incr_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int BW   = BW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BW-1:0]   burst,
  input  logic [DW-1:0]        gap,
  output logic                 incr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req is a level held until its one-cycle ack; gnt stays high
  // from the grant edge through the DONE cycle, and no burst is preempted.

  state_t          state, state_n;
  logic [BW-1:0]   remain, remain_n;
  logic [DW-1:0]   gap_q, gap_q_n;
  logic [DW-1:0]   gcnt, gcnt_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [LW-1:0]   widx, widx_n;
  logic [LW-1:0]   last, last_n;

  logic [NREQ-1:0] win;
  logic [LW-1:0]   win_idx;
  logic [BW-1:0]   sel_burst;

  rr_arbiter #(.NREQ(NREQ), .LW(LW)) u_arb (
    .req     (req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx)
  );

  assign sel_burst = burst[win_idx*BW +: BW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      remain <= '0;
      gap_q  <= '0;
      gcnt   <= '0;
      gnt_q  <= '0;
      widx   <= '0;
      last   <= LW'(NREQ - 1);
    end else begin
      state  <= state_n;
      remain <= remain_n;
      gap_q  <= gap_q_n;
      gcnt   <= gcnt_n;
      gnt_q  <= gnt_n;
      widx   <= widx_n;
      last   <= last_n;
    end
  end

  always_comb begin
    state_n  = state;
    remain_n = remain;
    gap_q_n  = gap_q;
    gcnt_n   = gcnt;
    gnt_n    = gnt_q;
    widx_n   = widx;
    last_n   = last;
    case (state)
      S_IDLE: begin
        if (|req) begin
          remain_n = sel_burst;
          gap_q_n  = gap;
          gnt_n    = win;
          widx_n   = win_idx;
          state_n  = (sel_burst == '0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        // A stalled pulse is simply re-presented once enable returns.
        if (enable) begin
          remain_n = remain - BW'(1);
          if (remain == BW'(1)) begin
            state_n = S_DONE;
          end else if (gap_q == '0) begin
            state_n = S_PULSE;
          end else begin
            gcnt_n  = gap_q;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (enable) begin
          if (gcnt == DW'(1)) begin
            state_n = S_PULSE;
          end else begin
            gcnt_n = gcnt - DW'(1);
          end
        end
      end
      S_DONE: begin
        last_n  = widx;
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign incr      = (state == S_PULSE) && enable;
  assign ack       = (state == S_DONE) ? gnt_q : '0;
  assign gnt       = gnt_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_grey_incr_sched.sv
// Directed bench for grey_incr_sched: per-cycle traces compared with hand-derived patterns.
module tb_grey_incr_sched;
  import grey_incr_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int BW   = 4;
  localparam int DW   = 4;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [NREQ-1:0]   req;
  logic [NREQ*BW-1:0] burst;
  logic [DW-1:0]     gap;
  logic              incr;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              busy;
  state_t            dbg_state;

  int n_tests;
  int n_fail;
  logic [NREQ-1:0] exp_q[$];

  grey_incr_sched #(.NREQ(NREQ), .BW(BW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req       (req),
    .burst     (burst),
    .gap       (gap),
    .incr      (incr),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records n cycles after the next edge; req bits are released on their ack.
  task automatic capture(input int n, input logic [31:0] en_mask,
                         output logic [31:0] incr_bits, output logic [31:0] ack_bits,
                         output logic [31:0] busy_bits, output logic [NREQ-1:0] first_gnt,
                         output logic [NREQ-1:0] ack_val);
    incr_bits = '0;
    ack_bits  = '0;
    busy_bits = '0;
    first_gnt = '0;
    ack_val   = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      enable = en_mask[c];
      #1;
      incr_bits[c] = incr;
      ack_bits[c]  = |ack;
      busy_bits[c] = busy;
      if (c == 0) first_gnt = gnt;
      if (|ack) ack_val = ack;
      req = req & ~ack;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_incr", {31'd0, incr}, 32'd0);
    check_eq("rst_gnt", {28'd0, gnt}, 32'd0);
    check_eq("rst_ack", {28'd0, ack}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [31:0]     ib, ab, bb;
  logic [NREQ-1:0] fg, av, prev_gnt;
  int              incr_cnt;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    enable  = 1'b1;
    req     = '0;
    burst   = '0;
    gap     = '0;

    do_reset();
    capture(2, 32'hFFFF_FFFF, ib, ab, bb, fg, av);
    check_eq("idle_busy", bb, 32'd0);

    // single burst: req0, burst 3, gap 0
    burst = {4'd0, 4'd0, 4'd0, 4'd3};
    gap   = 4'd0;
    req   = 4'b0001;
    capture(6, 32'hFFFF_FFFF, ib, ab, bb, fg, av);
    check_eq("single_gnt", {28'd0, fg}, 32'h1);
    check_eq("single_incr", ib, 32'h07);
    check_eq("single_ack", ab, 32'h08);
    check_eq("single_ackval", {28'd0, av}, 32'h1);
    check_eq("single_busy", bb, 32'h0F);

    // gap spacing: req1, burst 2, gap 3
    burst = {4'd0, 4'd0, 4'd2, 4'd0};
    gap   = 4'd3;
    req   = 4'b0010;
    capture(8, 32'hFFFF_FFFF, ib, ab, bb, fg, av);
    check_eq("gap_gnt", {28'd0, fg}, 32'h2);
    check_eq("gap_incr", ib, 32'h11);
    check_eq("gap_ack", ab, 32'h20);
    check_eq("gap_ackval", {28'd0, av}, 32'h2);
    check_eq("gap_busy", bb, 32'h3F);

    // fairness from a fresh reset: all request, burst 1 each
    do_reset();
    burst = {4'd1, 4'd1, 4'd1, 4'd1};
    gap   = 4'd0;
    req   = 4'b1111;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev_gnt = '0;
    incr_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #2;
      if (incr) incr_cnt++;
      if (gnt != '0 && prev_gnt == '0) begin
        if (exp_q.size() > 0) check_eq("fair_gnt", {28'd0, gnt}, {28'd0, exp_q.pop_front()});
        else check_eq("fair_extra_gnt", {28'd0, gnt}, 32'd0);
      end
      prev_gnt = gnt;
      if (c == 13) req = '0;
    end
    check_eq("fair_remaining", exp_q.size(), 32'd0);
    check_eq("fair_incr_cnt", incr_cnt, 32'd5);
    capture(1, 32'hFFFF_FFFF, ib, ab, bb, fg, av);

    // zero burst on requester 2
    burst = {4'd0, 4'd0, 4'd0, 4'd0};
    req   = 4'b0100;
    capture(3, 32'hFFFF_FFFF, ib, ab, bb, fg, av);
    check_eq("zero_gnt", {28'd0, fg}, 32'h4);
    check_eq("zero_incr", ib, 32'd0);
    check_eq("zero_ack", ab, 32'h1);
    check_eq("zero_ackval", {28'd0, av}, 32'h4);
    check_eq("zero_busy", bb, 32'h1);

    // enable stall: burst 3, gap 0, enable low for 4 cycles after first pulse
    burst = {4'd0, 4'd0, 4'd0, 4'd3};
    req   = 4'b0001;
    capture(10, 32'hFFFF_FFE1, ib, ab, bb, fg, av);
    check_eq("stall_gnt", {28'd0, fg}, 32'h1);
    check_eq("stall_incr", ib, 32'h061);
    check_eq("stall_ack", ab, 32'h080);
    check_eq("stall_busy", bb, 32'h0FF);
    enable = 1'b1;

    // async reset mid-burst: burst 5, reset after the second pulse
    burst = {4'd0, 4'd0, 4'd0, 4'd5};
    req   = 4'b0001;
    capture(2, 32'hFFFF_FFFF, ib, ab, bb, fg, av);
    check_eq("arst_pre_incr", ib, 32'h3);
    @(posedge clk);
    #2;
    check_eq("arst_live_incr", {31'd0, incr}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("arst_gnt", {28'd0, gnt}, 32'd0);
    check_eq("arst_incr", {31'd0, incr}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    req = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #2;
      check_eq("arst_no_ack", {28'd0, ack}, 32'd0);
    end
    rst = 1'b1;
    burst = {4'd0, 4'd0, 4'd1, 4'd0};
    req   = 4'b0010;
    capture(4, 32'hFFFF_FFFF, ib, ab, bb, fg, av);
    check_eq("arst_post_gnt", {28'd0, fg}, 32'h2);
    check_eq("arst_post_incr", ib, 32'h1);
    check_eq("arst_post_ack", ab, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
